// File: rtl/uart_pkg.sv
// Shared UART receive definitions: parity encodings, frame-checker FSM states and
// frame limits.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_EVEN  = 2'b00,
        PAR_ODD   = 2'b01,
        PAR_MARK  = 2'b10,
        PAR_SPACE = 2'b11
    } par_typ_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP1,
        ST_STOP2
    } rx_state_t;

    localparam int MIN_DATA_LEN = 5;
    localparam int MIN_PRESCALE = 8;

endpackage

// File: rtl/rx_sat_counter.sv
// Saturating event counter; a clear request overrides a simultaneous increment.
module rx_sat_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/rx_frame_checker.sv
// UART RX frame checker: follows start/data/parity/stop bits against the shared
// edge counter, deserialises data, flags errors and counts them.
module rx_frame_checker
    import uart_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int PRESCALE_WIDTH = 6,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      frame_start,
    input  logic                      sampled_bit,
    input  logic [PRESCALE_WIDTH-1:0] edge_cnt,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic                      PAR_EN,
    input  logic [1:0]                PAR_TYP,
    input  logic [3:0]                data_len,
    input  logic                      STOP2,
    input  logic                      err_clr,
    output logic [WIDTH-1:0]          P_data,
    output logic                      data_valid,
    output logic                      strt_glitch,
    output logic                      par_err,
    output logic                      stp_err,
    output logic                      busy,
    output logic [CNT_WIDTH-1:0]      par_err_cnt,
    output logic [CNT_WIDTH-1:0]      frm_err_cnt
);

    rx_state_t                 state_q, state_d;
    logic                      par_en_q, par_en_d;
    par_typ_t                  par_typ_q, par_typ_d;
    logic [3:0]                len_q, len_d;
    logic                      stop2_q, stop2_d;
    logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;
    logic [3:0]                bit_idx_q, bit_idx_d;
    logic                      acc_q, acc_d;
    logic [WIDTH-1:0]          p_data_q, p_data_d;
    logic                      data_valid_q, data_valid_d;
    logic                      strt_glitch_q, strt_glitch_d;
    logic                      par_err_q, par_err_d;
    logic                      stp_err_q, stp_err_d;

    logic [PRESCALE_WIDTH-1:0] eff_presc_in;
    logic [3:0]                len_in;
    logic [PRESCALE_WIDTH-1:0] sample_pt;
    logic                      at_sp, at_end, last_stop, start_go;
    logic                      par_exp, par_inc, frm_inc;

    // Unsupported ratios fall back to 8 so the sample point stays inside the bit.
    always_comb begin
        eff_presc_in = prescale;
        if (prescale[0] || (prescale < PRESCALE_WIDTH'(MIN_PRESCALE))) begin
            eff_presc_in = PRESCALE_WIDTH'(MIN_PRESCALE);
        end
        len_in = data_len;
        if (data_len < 4'(MIN_DATA_LEN)) begin
            len_in = 4'(MIN_DATA_LEN);
        end else if (data_len > 4'(WIDTH)) begin
            len_in = 4'(WIDTH);
        end
        sample_pt = (presc_q >> 1) + PRESCALE_WIDTH'(2);
        at_sp     = (edge_cnt == sample_pt);
        at_end    = (edge_cnt == (presc_q - PRESCALE_WIDTH'(1)));
        last_stop = ((state_q == ST_STOP1) && !stop2_q) || (state_q == ST_STOP2);
        start_go  = (state_q == ST_IDLE) && frame_start;
        case (par_typ_q)
            PAR_EVEN: par_exp = acc_q;
            PAR_ODD:  par_exp = ~acc_q;
            PAR_MARK: par_exp = 1'b1;
            default:  par_exp = 1'b0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (frame_start) state_d = ST_START;
            end
            ST_START: begin
                if (at_sp && sampled_bit) state_d = ST_IDLE;
                else if (at_end)          state_d = ST_DATA;
            end
            ST_DATA: begin
                if (at_end && (bit_idx_q == (len_q - 4'd1))) begin
                    state_d = par_en_q ? ST_PARITY : ST_STOP1;
                end
            end
            ST_PARITY: begin
                if (at_end) state_d = ST_STOP1;
            end
            ST_STOP1: begin
                if (at_sp && !stop2_q)      state_d = ST_IDLE;
                else if (at_end && stop2_q) state_d = ST_STOP2;
            end
            ST_STOP2: begin
                if (at_sp) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Frame end happens at the last stop sample, so flags and data_valid are decided there.
    always_comb begin
        par_en_d      = par_en_q;
        par_typ_d     = par_typ_q;
        len_d         = len_q;
        stop2_d       = stop2_q;
        presc_d       = presc_q;
        bit_idx_d     = bit_idx_q;
        acc_d         = acc_q;
        p_data_d      = p_data_q;
        data_valid_d  = 1'b0;
        strt_glitch_d = strt_glitch_q;
        par_err_d     = par_err_q;
        stp_err_d     = stp_err_q;
        par_inc       = 1'b0;
        frm_inc       = 1'b0;
        if (start_go) begin
            par_en_d      = PAR_EN;
            par_typ_d     = par_typ_t'(PAR_TYP);
            len_d         = len_in;
            stop2_d       = STOP2;
            presc_d       = eff_presc_in;
            bit_idx_d     = '0;
            acc_d         = 1'b0;
            p_data_d      = '0;
            strt_glitch_d = 1'b0;
            par_err_d     = 1'b0;
            stp_err_d     = 1'b0;
        end
        case (state_q)
            ST_START: begin
                if (at_sp && sampled_bit) begin
                    strt_glitch_d = 1'b1;
                    frm_inc       = 1'b1;
                end
            end
            ST_DATA: begin
                if (at_sp) begin
                    p_data_d = p_data_q | (WIDTH'(sampled_bit) << bit_idx_q);
                    acc_d    = acc_q ^ sampled_bit;
                end
                if (at_end) bit_idx_d = bit_idx_q + 4'd1;
            end
            ST_PARITY: begin
                if (at_sp && (sampled_bit != par_exp)) begin
                    par_err_d = 1'b1;
                    par_inc   = 1'b1;
                end
            end
            ST_STOP1, ST_STOP2: begin
                if (at_sp) begin
                    if (!sampled_bit && !stp_err_q) begin
                        stp_err_d = 1'b1;
                        frm_inc   = 1'b1;
                    end
                    if (last_stop) begin
                        data_valid_d = sampled_bit && !stp_err_q && !par_err_q;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            par_en_q      <= 1'b0;
            par_typ_q     <= PAR_EVEN;
            len_q         <= 4'(MIN_DATA_LEN);
            stop2_q       <= 1'b0;
            presc_q       <= PRESCALE_WIDTH'(MIN_PRESCALE);
            bit_idx_q     <= '0;
            acc_q         <= 1'b0;
            p_data_q      <= '0;
            data_valid_q  <= 1'b0;
            strt_glitch_q <= 1'b0;
            par_err_q     <= 1'b0;
            stp_err_q     <= 1'b0;
        end else begin
            par_en_q      <= par_en_d;
            par_typ_q     <= par_typ_d;
            len_q         <= len_d;
            stop2_q       <= stop2_d;
            presc_q       <= presc_d;
            bit_idx_q     <= bit_idx_d;
            acc_q         <= acc_d;
            p_data_q      <= p_data_d;
            data_valid_q  <= data_valid_d;
            strt_glitch_q <= strt_glitch_d;
            par_err_q     <= par_err_d;
            stp_err_q     <= stp_err_d;
        end
    end

    rx_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_par_cnt (
        .clk   (CLK),
        .rst   (RST),
        .inc   (par_inc),
        .clr   (err_clr),
        .count (par_err_cnt)
    );

    rx_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_frm_cnt (
        .clk   (CLK),
        .rst   (RST),
        .inc   (frm_inc),
        .clr   (err_clr),
        .count (frm_err_cnt)
    );

    assign P_data      = p_data_q;
    assign data_valid  = data_valid_q;
    assign strt_glitch = strt_glitch_q;
    assign par_err     = par_err_q;
    assign stp_err     = stp_err_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rx_frame_checker.sv
// Directed bench for rx_frame_checker: bit-level UART frames with hand-computed
// expectations; counters use a 2-bit width so saturation is quick to reach.
module tb_rx_frame_checker;

    logic       CLK = 1'b0;
    logic       RST;
    logic       frame_start;
    logic       sampled_bit;
    logic [5:0] edge_cnt;
    logic [5:0] prescale;
    logic       PAR_EN;
    logic [1:0] PAR_TYP;
    logic [3:0] data_len;
    logic       STOP2;
    logic       err_clr;
    logic [7:0] P_data;
    logic       data_valid;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic       busy;
    logic [1:0] par_err_cnt;
    logic [1:0] frm_err_cnt;

    int tests = 0;
    int fails = 0;
    int dv_pulses = 0;
    int dv_base;

    rx_frame_checker #(.WIDTH(8), .PRESCALE_WIDTH(6), .CNT_WIDTH(2)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .frame_start (frame_start),
        .sampled_bit (sampled_bit),
        .edge_cnt    (edge_cnt),
        .prescale    (prescale),
        .PAR_EN      (PAR_EN),
        .PAR_TYP     (PAR_TYP),
        .data_len    (data_len),
        .STOP2       (STOP2),
        .err_clr     (err_clr),
        .P_data      (P_data),
        .data_valid  (data_valid),
        .strt_glitch (strt_glitch),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .busy        (busy),
        .par_err_cnt (par_err_cnt),
        .frm_err_cnt (frm_err_cnt)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (data_valid === 1'b1) dv_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic int sp_of(input int eff);
        return eff / 2 + 2;
    endfunction

    task automatic bit_part(input logic b, input int lo, input int hi);
        for (int e = lo; e <= hi; e++) begin
            edge_cnt    = 6'(e);
            sampled_bit = b;
            tick();
        end
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        edge_cnt    = 6'd0;
        sampled_bit = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    // Config inputs are scrambled during the frame to prove they were latched at the start.
    task automatic send_frame(input logic [8:0] data, input int len, input logic has_par,
                              input logic par_bit, input logic exp_par, input logic two_stop,
                              input logic s1, input logic s2, input int eff, input logic clr_at_par);
        logic [5:0] sv_presc;
        logic [3:0] sv_len;
        logic [1:0] sv_typ;
        logic       sv_en, sv_stop2;
        int         sp;
        sp       = sp_of(eff);
        sv_presc = prescale;
        sv_len   = data_len;
        sv_typ   = PAR_TYP;
        sv_en    = PAR_EN;
        sv_stop2 = STOP2;
        start_frame();
        prescale = 6'd40;
        data_len = 4'd9;
        PAR_TYP  = ~sv_typ;
        PAR_EN   = ~sv_en;
        STOP2    = ~sv_stop2;
        bit_part(1'b0, 0, eff - 1);
        for (int i = 0; i < len; i++) bit_part(data[i], 0, eff - 1);
        if (has_par) begin
            if (clr_at_par) begin
                bit_part(par_bit, 0, sp - 1);
                err_clr = 1'b1;
                bit_part(par_bit, sp, sp);
                err_clr = 1'b0;
            end else begin
                bit_part(par_bit, 0, sp);
            end
            check("par_err_after_par_sp", par_err, exp_par);
            bit_part(par_bit, sp + 1, eff - 1);
        end
        if (two_stop) begin
            bit_part(s1, 0, eff - 1);
            bit_part(s2, 0, sp);
        end else begin
            bit_part(s1, 0, sp);
        end
        prescale = sv_presc;
        data_len = sv_len;
        PAR_TYP  = sv_typ;
        PAR_EN   = sv_en;
        STOP2    = sv_stop2;
    endtask

    initial begin
        RST = 1'b1; frame_start = 1'b0; sampled_bit = 1'b1; edge_cnt = 6'd0;
        prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 2'b00; data_len = 4'd8;
        STOP2 = 1'b0; err_clr = 1'b0;
        tick(); tick(); tick();
        RST = 1'b0;
        tick();
        check("rst_P_data", P_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_data_valid", data_valid, 1'b0);
        check("rst_flags", {strt_glitch, par_err, stp_err}, 3'b000);
        check("rst_counters", {par_err_cnt, frm_err_cnt}, 4'h0);

        // Even parity, 0xA5 (four ones -> parity 0)
        PAR_EN = 1'b1; PAR_TYP = 2'b00; data_len = 4'd8; prescale = 6'd8;
        dv_base = dv_pulses;
        send_frame(9'h0A5, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8, 1'b0);
        check("t1_data_valid", data_valid, 1'b1);
        check("t1_P_data", P_data, 8'hA5);
        check("t1_stp_err", stp_err, 1'b0);
        check("t1_busy_after_stop_sp", busy, 1'b0);
        tick();
        check("t1_dv_one_cycle", data_valid, 1'b0);
        check("t1_dv_pulse_count", dv_pulses - dv_base, 1);

        // Same frame, wrong parity bit
        dv_base = dv_pulses;
        send_frame(9'h0A5, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8, 1'b0);
        check("t2_data_valid", data_valid, 1'b0);
        check("t2_par_err_cnt", par_err_cnt, 2'd1);
        tick();
        check("t2_no_dv_pulse", dv_pulses - dv_base, 0);
        check("t2_par_err_held", par_err, 1'b1);

        // Odd parity, 7 bits, 0x41 (two ones -> parity 1), prescale 16 then 11 (acts as 8)
        PAR_TYP = 2'b01; data_len = 4'd7; prescale = 6'd16;
        send_frame(9'h041, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 16, 1'b0);
        check("t3_p16_data_valid", data_valid, 1'b1);
        check("t3_p16_P_data", P_data, 8'h41);
        prescale = 6'd11;
        send_frame(9'h041, 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8, 1'b0);
        check("t3_p11_data_valid", data_valid, 1'b1);
        check("t3_p11_P_data", P_data, 8'h41);

        // Space parity with data_len 2 clamped to 5, then data_len 12 clamped to 8 without parity
        prescale = 6'd8; PAR_TYP = 2'b11; data_len = 4'd2;
        send_frame(9'h016, 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8, 1'b0);
        check("t3b_len_lo_dv", data_valid, 1'b1);
        check("t3b_len_lo_P_data", P_data, 8'h16);
        PAR_EN = 1'b0; data_len = 4'd12;
        send_frame(9'h0C3, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8, 1'b0);
        check("t3b_len_hi_dv", data_valid, 1'b1);
        check("t3b_len_hi_P_data", P_data, 8'hC3);

        // Mark parity, two stop bits, second stop low; then both stops low
        PAR_EN = 1'b1; PAR_TYP = 2'b10; data_len = 4'd8; STOP2 = 1'b1;
        send_frame(9'h03C, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8, 1'b0);
        check("t4_stp_err", stp_err, 1'b1);
        check("t4_data_valid", data_valid, 1'b0);
        check("t4_frm_err_cnt", frm_err_cnt, 2'd1);
        send_frame(9'h03C, 8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8, 1'b0);
        check("t4b_stp_err", stp_err, 1'b1);
        check("t4b_frm_once_per_frame", frm_err_cnt, 2'd2);

        // Start glitch: line high at the start sample point
        STOP2 = 1'b0;
        start_frame();
        check("t5_busy_in_start", busy, 1'b1);
        check("t5_glitch_cleared", strt_glitch, 1'b0);
        bit_part(1'b1, 0, 6);
        check("t5_strt_glitch", strt_glitch, 1'b1);
        check("t5_busy_drops", busy, 1'b0);
        check("t5_frm_err_cnt", frm_err_cnt, 2'd3);
        start_frame();
        bit_part(1'b1, 0, 6);
        check("t5_frm_saturates", frm_err_cnt, 2'd3);
        check("t5_par_cnt_kept", par_err_cnt, 2'd1);

        // Reset in the middle of the data bits
        PAR_TYP = 2'b00;
        start_frame();
        bit_part(1'b0, 0, 7);
        bit_part(1'b1, 0, 7);
        bit_part(1'b1, 0, 6);
        check("t7_busy_mid_data", busy, 1'b1);
        check("t7_partial_P_data", P_data, 8'h03);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("t7_rst_P_data", P_data, 8'h00);
        check("t7_rst_busy", busy, 1'b0);
        check("t7_rst_flags_dv", {strt_glitch, par_err, stp_err, data_valid}, 4'h0);
        check("t7_rst_counters", {par_err_cnt, frm_err_cnt}, 4'h0);
        tick();
        send_frame(9'h0A5, 8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8, 1'b0);
        check("t7_after_rst_dv", data_valid, 1'b1);
        check("t7_after_rst_P_data", P_data, 8'hA5);

        // Parity-error saturation on the 2-bit counter, then clear racing an increment
        for (int k = 1; k <= 5; k++) begin
            send_frame(9'h000, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8, 1'b0);
            check("t6_par_err_cnt", par_err_cnt, (k > 3) ? 2'd3 : 2'(k));
        end
        send_frame(9'h000, 8, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8, 1'b1);
        check("t6_clr_wins", par_err_cnt, 2'd0);
        check("t6_dv_on_par_err", data_valid, 1'b0);

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/rx_frame_checker.md
Name: rx_frame_checker

Overview:
Parametrised successor to the RX parity checker. Tracks a full UART frame (start, 5..WIDTH data bits, optional parity, 1 or 2 stop bits) against the shared edge counter. Parity is accumulated serially as data bits arrive, with four parity modes. Reports start-glitch, parity and stop errors, emits deserialised data with a valid pulse, and keeps saturating error counters. Sits in UART_RX between the edge/bit counter plus data sampler and the RX top-level output registers.

Parameters:
WIDTH, 8, maximum data bits per frame (5..9)
PRESCALE_WIDTH, 6, width of prescale and edge_cnt
CNT_WIDTH, 8, width of each saturating error counter

Ports:
CLK  in  1  clock
RST  in  1  reset, synchronous, active-high
frame_start  in  1  1-cycle pulse on start-edge detect; edge_cnt is 0 on the following cycle
sampled_bit  in  1  majority-sampled line value
edge_cnt  in  PRESCALE_WIDTH  oversample edge count, 0..prescale-1, wraps
prescale  in  PRESCALE_WIDTH  oversampling ratio
PAR_EN  in  1  parity bit present
PAR_TYP  in  2  00 even, 01 odd, 10 mark (1), 11 space (0)
data_len  in  4  data bits per frame
STOP2  in  1  two stop bits
err_clr  in  1  clears both error counters
P_data  out  WIDTH  received data, LSB first, right-aligned, upper bits 0
data_valid  out  1  1-cycle pulse for a good frame
strt_glitch  out  1  start bit sampled high
par_err  out  1  parity mismatch
stp_err  out  1  stop bit sampled low
busy  out  1  frame in progress
par_err_cnt  out  CNT_WIDTH  saturating parity-error count
frm_err_cnt  out  CNT_WIDTH  saturating framing-error count (start glitch or stop error)

Behaviour:
- Reset (RST high at CLK edge): state IDLE; all outputs 0, including both counters. RST mid-frame aborts with no flags or pulses.
- Sample point: sp = prescale/2 + 2, giving 6/10/18 for 8/16/32. Any prescale that is odd or below 8 is treated as 8.
- Bit end: edge_cnt == eff_prescale-1.
- Config latch: PAR_EN, PAR_TYP, data_len, STOP2 and eff_prescale are latched on the frame_start cycle and held for the whole frame.
- data_len clamp: below 5 is treated as 5; above WIDTH is treated as WIDTH.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE -> START on frame_start. On this transition clear P_data, the parity accumulator, par_err, stp_err and strt_glitch. frame_start is ignored while busy.
  - START: at sp, if sampled_bit is 1, set strt_glitch, increment frm_err_cnt and return to IDLE on the next cycle. Otherwise go to DATA at bit end.
  - DATA: at sp, shift sampled_bit into bit position bit_idx of P_data and XOR it into the accumulator. At bit end, increment bit_idx. After bit data_len-1, go to PARITY if PAR_EN is set, else STOP1.
  - PARITY: expected bit is acc (even), ~acc (odd), 1 (mark) or 0 (space). At sp, set par_err on mismatch and increment par_err_cnt. Go to STOP1 at bit end.
  - STOP1 / STOP2: at sp, set stp_err if sampled_bit is 0 and increment frm_err_cnt, at most once per frame. STOP1 goes to STOP2 when STOP2 is latched.
  - Frame end: on the cycle after sp of the last stop bit, return to IDLE. Do not wait for bit end, so a back-to-back frame_start is accepted.
- data_valid: asserted on the cycle after sp of the last stop bit, only if par_err and stp_err are both 0.
- Flag timing: par_err, stp_err and strt_glitch are registered one cycle after the deciding sample and hold until the next frame_start.
- busy: 1 in every state except IDLE.
- Counters: saturate at all-ones. If err_clr coincides with an increment, clear wins and the counter reads 0.

Decomposition:
- Shared package uart_pkg: PAR_TYP encodings (PAR_EVEN, PAR_ODD, PAR_MARK, PAR_SPACE), FSM state encoding, MIN_DATA_LEN = 5, MIN_PRESCALE = 8.
- One sub-module: rx_sat_counter (CNT_WIDTH; inputs inc and clr, clr priority), instanced twice.

Test Plan:
- Prescale 8, 8-bit, even parity: send 0xA5 LSB first with parity 0 and one stop bit -> P_data=0xA5, data_valid pulses once, par_err=0, stp_err=0.
- Same frame with parity bit 1 -> par_err=1 one cycle after the parity sample point, no data_valid, par_err_cnt=1.
- Prescale 16, data_len 7, odd parity: send 0x41 with parity 1 -> P_data=0x41, data_valid pulses; repeat with prescale 11 -> timing behaves as prescale 8.
- Mark parity, STOP2=1, second stop bit 0 -> stp_err=1, frm_err_cnt=1, no data_valid.
- Line high at the start sample point -> strt_glitch=1, busy drops the next cycle, frm_err_cnt increments.
- CNT_WIDTH=2, 5 parity errors -> par_err_cnt=3; err_clr coinciding with a 6th error -> 0.
- RST asserted mid-DATA -> all outputs 0 next cycle; the next frame is received correctly.
